// File: rtl/psmac_seq.sv
// psmac_seq: job sequencer and saturating accumulator for the precision-scalable MAC datapath.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid/cfg_ready      job descriptor handshake (cfg_prec, cfg_sx, cfg_sy, cfg_len)
//   in_valid/in_ready        operand beat handshake (in_ip, in_wt)
//   mac_ip, mac_wt           registered operands to the datapath
//   mac_sx, mac_sy           per-slice sign selects to the datapath
//   mac_mode1, mac_mode2     datapath precision mode
//   mac_y                    datapath registered result, returned two cycles after a beat
//   out_valid/out_ready      result handshake (out_acc, out_sat)
module psmac_seq #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_prec,
   input  logic             cfg_sx,
   input  logic             cfg_sy,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_ip,
   input  logic [31:0]      in_wt,
   output logic [31:0]      mac_ip,
   output logic [31:0]      mac_wt,
   output logic [15:0]      mac_sx,
   output logic [15:0]      mac_sy,
   output logic             mac_mode1,
   output logic             mac_mode2,
   input  logic [15:0]      mac_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_sat
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [31:0]      ip_q, wt_q;
   logic [15:0]      sx_q, sy_q;
   logic             mode1_q, mode2_q;
   logic             ext_q;
   logic             v1_q, v2_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;

   logic             cfg_hs;
   logic             beat_hs;
   logic [15:0]      mask;
   logic [ACC_W-1:0] y_ext;
   logic [ACC_W:0]   sum;

   assign cfg_hs  = cfg_valid & cfg_ready;
   assign beat_hs = in_valid & in_ready;

   // Slice sign-select pattern: every slice's MSB position carries the sign.
   always_comb begin
      mask = 16'h8888;
      unique case (cfg_prec)
         2'd0:    mask = 16'hFFFF;
         2'd1:    mask = 16'hAAAA;
         default: mask = 16'h8888;
      endcase
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               rem_d   = cfg_len;
               state_d = (cfg_len == '0) ? StDrain : StRun;
            end
         end
         StRun: begin
            in_ready = (rem_q != '0);
            if (in_valid && (rem_q != '0)) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            // No new beats enter here; once slot 1 is empty the last y is being added this cycle.
            if (!v1_q) state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Extension and saturating accumulation.
   assign y_ext = ext_q ? {{(ACC_W-16){mac_y[15]}}, mac_y} : {{(ACC_W-16){1'b0}}, mac_y};
   assign sum   = {acc_q[ACC_W-1], acc_q} + {y_ext[ACC_W-1], y_ext};

   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      if (cfg_hs) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (v2_q) begin
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            // Overflow: the extra sign bit tells which limit to clamp to.
            sat_d = 1'b1;
            acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= '0;
         ip_q    <= '0;
         wt_q    <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         mode1_q <= 1'b0;
         mode2_q <= 1'b0;
         ext_q   <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         v1_q    <= beat_hs;
         v2_q    <= v1_q;
         if (beat_hs) begin
            ip_q <= in_ip;
            wt_q <= in_wt;
         end
         if (cfg_hs) begin
            mode1_q <= (cfg_prec != 2'd0);
            mode2_q <= cfg_prec[1];
            sx_q    <= cfg_sx ? mask : 16'h0000;
            sy_q    <= cfg_sy ? mask : 16'h0000;
            ext_q   <= cfg_sx | cfg_sy;
         end
      end
   end

   assign mac_ip    = ip_q;
   assign mac_wt    = wt_q;
   assign mac_sx    = sx_q;
   assign mac_sy    = sy_q;
   assign mac_mode1 = mode1_q;
   assign mac_mode2 = mode2_q;
   assign out_acc   = acc_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_psmac_seq.sv
// tb_psmac_seq: randomized self-checking bench for psmac_seq. Two instances (ACC_W=32 and
// ACC_W=17) share all inputs; the datapath is modelled as scripted y values returned two
// cycles after each beat handshake.
module tb_psmac_seq;
   localparam int unsigned LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_valid;
   logic [1:0]       cfg_prec;
   logic             cfg_sx, cfg_sy;
   logic [LEN_W-1:0] cfg_len;
   logic             in_valid;
   logic [31:0]      in_ip, in_wt;
   logic [15:0]      mac_y;
   logic             out_ready;

   logic        a_cfg_ready, a_in_ready, a_mode1, a_mode2, a_out_valid, a_out_sat;
   logic [31:0] a_mac_ip, a_mac_wt, a_out_acc;
   logic [15:0] a_mac_sx, a_mac_sy;
   logic        b_cfg_ready, b_in_ready, b_mode1, b_mode2, b_out_valid, b_out_sat;
   logic [31:0] b_mac_ip, b_mac_wt;
   logic [16:0] b_out_acc;
   logic [15:0] b_mac_sx, b_mac_sy;

   always #5 clk = ~clk;

   psmac_seq #(.ACC_W(32), .LEN_W(LEN_W)) dut_a (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready),
      .cfg_prec(cfg_prec), .cfg_sx(cfg_sx), .cfg_sy(cfg_sy), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_ip(in_ip), .in_wt(in_wt),
      .mac_ip(a_mac_ip), .mac_wt(a_mac_wt), .mac_sx(a_mac_sx), .mac_sy(a_mac_sy),
      .mac_mode1(a_mode1), .mac_mode2(a_mode2), .mac_y(mac_y),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc), .out_sat(a_out_sat)
   );

   psmac_seq #(.ACC_W(17), .LEN_W(LEN_W)) dut_b (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready),
      .cfg_prec(cfg_prec), .cfg_sx(cfg_sx), .cfg_sy(cfg_sy), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_ip(in_ip), .in_wt(in_wt),
      .mac_ip(b_mac_ip), .mac_wt(b_mac_wt), .mac_sx(b_mac_sx), .mac_sy(b_mac_sy),
      .mac_mode1(b_mode1), .mac_mode2(b_mode2), .mac_y(mac_y),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc), .out_sat(b_out_sat)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] ys [16];
   int          bi;
   logic        hs_seen;
   logic [15:0] st1 = 16'h0;
   logic [15:0] st2 = 16'h0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: record the beat handshake, advance the two-stage datapath model.
   task automatic tick();
      hs_seen = in_valid && a_in_ready;
      @(posedge clk);
      st2 = st1;
      st1 = hs_seen ? ys[bi % 16] : 16'($urandom);
      if (hs_seen) bi++;
      @(negedge clk);
      mac_y = st2;
   endtask

   // Saturating sum of the first n scripted y values at width w.
   task automatic model_acc(input int w, input int n, input bit sext,
                            output logic [63:0] acc, output bit sat);
      longint a, mx, mn, v;
      a   = 0;
      sat = 1'b0;
      mx  = (longint'(1) <<< (w - 1)) - 1;
      mn  = -(longint'(1) <<< (w - 1));
      for (int i = 0; i < n; i++) begin
         v = sext ? longint'($signed(ys[i])) : longint'({48'h0, ys[i]});
         a = a + v;
         if (a > mx) begin a = mx; sat = 1'b1; end
         if (a < mn) begin a = mn; sat = 1'b1; end
      end
      acc = 64'(a) & ((64'd1 << w) - 64'd1);
   endtask

   function automatic logic [15:0] exp_mask(input logic [1:0] prec);
      if (prec == 2'd0) return 16'hFFFF;
      if (prec == 2'd1) return 16'hAAAA;
      return 16'h8888;
   endfunction

   task automatic check_cfg(input string name, input logic [1:0] prec, input bit sx, input bit sy);
      check_eq({name, ":mode1"}, {a_mode1, b_mode1}, (prec != 2'd0) ? 2'b11 : 2'b00);
      check_eq({name, ":mode2"}, {a_mode2, b_mode2}, (prec >= 2'd2) ? 2'b11 : 2'b00);
      check_eq({name, ":mac_sx"}, {a_mac_sx, b_mac_sx},
               sx ? {exp_mask(prec), exp_mask(prec)} : 32'h0);
      check_eq({name, ":mac_sy"}, {a_mac_sy, b_mac_sy},
               sy ? {exp_mask(prec), exp_mask(prec)} : 32'h0);
   endtask

   task automatic run_job(input string name, input logic [1:0] prec, input bit sx, input bit sy,
                          input int len, input bit bubbles, input int hold);
      int          cyc, got, since, rdy_hi;
      logic [63:0] last_opnd, e32, e17, acc_hold;
      bit          s32, s17;
      bi  = 0;
      cyc = 0;
      while (!a_cfg_ready && cyc < 50) begin tick(); cyc++; end
      check_eq({name, ":cfg_ready"}, a_cfg_ready, 1'b1);
      cfg_valid = 1'b1; cfg_prec = prec; cfg_sx = sx; cfg_sy = sy; cfg_len = LEN_W'(len);
      tick();
      cfg_valid = 1'b0;
      check_cfg(name, prec, sx, sy);
      since     = 1;
      got       = 0;
      cyc       = 0;
      last_opnd = '0;
      while (got < len && cyc < 200) begin
         in_valid = bubbles ? (cyc % 2 == 0) : 1'b1;
         in_ip    = $urandom;
         in_wt    = $urandom;
         if (in_valid && a_in_ready) last_opnd = {in_ip, in_wt};
         tick();
         if (hs_seen) begin got++; since = 1; end else since++;
         if (got > 0) check_eq({name, ":mac_opnd"}, {a_mac_ip, a_mac_wt}, last_opnd);
         cyc++;
      end
      in_valid = 1'b0;
      check_eq({name, ":beats"}, got, len);
      rdy_hi = 0;
      while (!a_out_valid && since < 20) begin
         if (a_in_ready) rdy_hi++;
         tick();
         since++;
      end
      check_eq({name, ":in_ready_idle"}, rdy_hi, 0);
      check_eq({name, ":latency"}, since, (len == 0) ? 2 : 3);
      check_eq({name, ":out_valid"}, {a_out_valid, b_out_valid}, 2'b11);
      model_acc(32, len, sx | sy, e32, s32);
      model_acc(17, len, sx | sy, e17, s17);
      check_eq({name, ":acc32"}, a_out_acc, e32);
      check_eq({name, ":sat32"}, a_out_sat, s32);
      check_eq({name, ":acc17"}, b_out_acc, e17);
      check_eq({name, ":sat17"}, b_out_sat, s17);
      acc_hold = {b_out_acc, a_out_acc};
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         if (h == 1) begin
            // This descriptor must be dropped: the sequencer is busy.
            cfg_valid = 1'b1; cfg_prec = ~prec; cfg_sx = ~sx; cfg_sy = ~sy; cfg_len = 8'd5;
         end
         tick();
         cfg_valid = 1'b0;
         check_eq({name, ":hold_acc"}, {b_out_acc, a_out_acc}, acc_hold);
         check_eq({name, ":hold_valid"}, a_out_valid, 1'b1);
         check_eq({name, ":hold_cfg_ready"}, a_cfg_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({name, ":post_valid"}, a_out_valid, 1'b0);
      check_eq({name, ":post_cfg_ready"}, a_cfg_ready, 1'b1);
      check_cfg({name, ":kept"}, prec, sx, sy);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int nb, cyc;
      rst = 1'b1; cfg_valid = 1'b0; cfg_prec = 2'd0; cfg_sx = 1'b0; cfg_sy = 1'b0;
      cfg_len = '0; in_valid = 1'b0; in_ip = '0; in_wt = '0; mac_y = '0; out_ready = 1'b0;
      bi = 0;
      for (int i = 0; i < 16; i++) ys[i] = '0;
      @(negedge clk);
      @(negedge clk);
      check_eq("reset:cfg_ready", a_cfg_ready, 1'b1);
      check_eq("reset:in_ready", a_in_ready, 1'b0);
      check_eq("reset:out", {a_out_valid, a_out_sat, a_out_acc}, 34'h0);
      rst = 1'b0;

      // Reset in the middle of a job with two beats in flight.
      for (int i = 0; i < 16; i++) ys[i] = 16'h1000;
      cfg_valid = 1'b1; cfg_prec = 2'd2; cfg_sx = 1'b1; cfg_sy = 1'b0; cfg_len = 8'd6;
      tick();
      cfg_valid = 1'b0;
      nb  = 0;
      cyc = 0;
      while (nb < 3 && cyc < 20) begin
         in_valid = 1'b1; in_ip = $urandom; in_wt = $urandom;
         tick();
         if (hs_seen) nb++;
         cyc++;
      end
      in_valid = 1'b0;
      check_eq("rst_mid:beats", nb, 3);
      check_eq("rst_mid:pre_acc", a_out_acc, 32'h1000);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_mid:cfg_ready", a_cfg_ready, 1'b1);
      check_eq("rst_mid:in_ready", a_in_ready, 1'b0);
      check_eq("rst_mid:out", {a_out_valid, a_out_sat, a_out_acc, b_out_acc}, 51'h0);
      check_eq("rst_mid:mac_opnd", {a_mac_ip, a_mac_wt}, 64'h0);
      check_eq("rst_mid:mac_sel", {a_mac_sx, a_mac_sy, a_mode1, a_mode2}, 34'h0);
      tick();
      rst = 1'b0;
      ys[0] = 16'h0123;
      run_job("after_rst", 2'd2, 1'b0, 1'b0, 1, 1'b0, 0);

      ys[0] = 16'hFFFF; ys[1] = 16'h0001; ys[2] = 16'h0010;
      run_job("u8", 2'd2, 1'b0, 1'b0, 3, 1'b0, 0);

      ys[0] = 16'hFFF0; ys[1] = 16'h0005;
      run_job("s4_ip", 2'd1, 1'b1, 1'b0, 2, 1'b0, 0);

      for (int i = 0; i < 4; i++) ys[i] = 16'h0002;
      run_job("s2_bub", 2'd0, 1'b1, 1'b1, 4, 1'b1, 5);

      for (int i = 0; i < 3; i++) ys[i] = 16'h7FFF;
      run_job("sat8", 2'd2, 1'b1, 1'b1, 3, 1'b0, 0);

      ys[0] = 16'h0001; ys[1] = 16'h0001;
      run_job("sat_clear", 2'd0, 1'b0, 1'b0, 2, 1'b0, 0);

      run_job("zero_len", 2'd1, 1'b0, 1'b1, 0, 1'b0, 2);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) ys[i] = 16'($urandom);
         run_job($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), int'($urandom_range(1, 8)), 1'($urandom),
                 int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
